// File: rtl/maxpool2d_stream_pkg.sv
// -----------------------------------------------------------------------------
// maxpool2d_stream_pkg
//
// Shared definitions for the 2x2 max-pooling stage that follows the conv2d
// engine:
//   - default sample width and output BRAM address width
//   - pooling FSM state encoding (IDLE / RUN / FLUSH)
//   - layout of the top-level controller's ctrl word, so the controller and
//     every stage agree on where each control bit lives
// -----------------------------------------------------------------------------
package maxpool2d_stream_pkg;

   // Conv result samples are 16-bit signed two's complement.
   localparam int MP_DATA_WIDTH = 16;

   // Output image BRAM address width.
   localparam int MP_ADDR_WIDTH = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Ctrl word as seen by the top-level controller, MSB first:
   //   [8:5] layer, [4] maxpool, [3] bn_relu, [2] conv, [1] done, [0] start
   typedef struct packed {
      logic [3:0] layer;
      logic       maxpool;
      logic       bn_relu;
      logic       conv;
      logic       done;
      logic       start;
   } ctrl_word_t;

endpackage : maxpool2d_stream_pkg

// File: rtl/maxpool_line_buf.sv
// -----------------------------------------------------------------------------
// maxpool_line_buf
//
// One row's worth of horizontal pair maxima. Synchronous write, asynchronous
// read. The pooling stage writes on even rows and reads on odd rows, so a
// read and a write never target the same entry in the same cycle.
//
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write index (pair column)
//   i_wdata  value to store
//   i_raddr  read index (pair column)
//   o_rdata  stored value at i_raddr, combinational
// -----------------------------------------------------------------------------
module maxpool_line_buf #(
   parameter int DEPTH      = 128,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 7
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   // NOTE: the array has no reset. Every entry is written on an even row
   // before the odd row that reads it, so power-up contents never reach the
   // output, and leaving it unreset lets it map onto plain storage.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule : maxpool_line_buf

// File: rtl/maxpool2d_stream.sv
// -----------------------------------------------------------------------------
// maxpool2d_stream
//
// 2x2 / stride-2 max-pooling of the conv2d result stream (raster order:
// channel, row, column). Pooled values are written to the output image BRAM
// at consecutive addresses starting from 0. Odd trailing columns / rows are
// dropped (floor semantics). No backpressure; full-rate i_valid is sustained.
//
// Optional build macro:
//   MAXPOOL_RELU_EN  when defined, negative pooled results are written as 0.
//
// Ports:
//   i_clk     clock
//   i_rst     asynchronous active-low reset
//   i_start   one-cycle pulse: latch dimensions, begin a pass (IDLE only)
//   i_width   input columns per row
//   i_height  input rows per channel
//   i_max_ch  channels in the pass
//   i_data    conv result sample (signed)
//   i_valid   i_data valid this cycle
//   o_addr    output BRAM write address
//   o_we      output BRAM write enable
//   o_data    pooled value
//   o_done    one-cycle pulse at end of pass
// -----------------------------------------------------------------------------
module maxpool2d_stream
   import maxpool2d_stream_pkg::*;
#(
   parameter int DATA_WIDTH = MP_DATA_WIDTH,
   parameter int LB_DEPTH   = 128,
   parameter int ADDR_WIDTH = MP_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_width,
   input  logic [7:0]            i_height,
   input  logic [9:0]            i_max_ch,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_we,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_done
);

   localparam int LB_AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   state_t                       state;
   logic [7:0]                   cfg_width;
   logic [7:0]                   cfg_height;
   logic [9:0]                   cfg_max_ch;
   logic [7:0]                   col;
   logic [7:0]                   row;
   logic [9:0]                   ch;
   logic [ADDR_WIDTH-1:0]        addr_cnt;   // address of the next write

   logic signed [DATA_WIDTH-1:0] sample;
   logic signed [DATA_WIDTH-1:0] pair;       // even-column sample awaiting its partner
   logic signed [DATA_WIDTH-1:0] pmax;       // horizontal max of the current pair
   logic signed [DATA_WIDTH-1:0] lb_rdata;   // horizontal max from the row above
   logic signed [DATA_WIDTH-1:0] vmax;
   logic signed [DATA_WIDTH-1:0] result;

   logic                         accept;
   logic                         col_last;
   logic                         row_last;
   logic                         ch_last;
   logic                         lb_we;
   logic [LB_AW-1:0]             lb_addr;

   assign sample   = $signed(i_data);
   assign accept   = (state == RUN) && i_valid;

   assign col_last = (col == cfg_width  - 8'd1);
   assign row_last = (row == cfg_height - 8'd1);
   assign ch_last  = (ch  == cfg_max_ch - 10'd1);

   // Each odd column closes a pair; its slot in the line buffer is col/2.
   assign lb_addr  = LB_AW'(col >> 1);
   assign lb_we    = accept && col[0] && !row[0];

   assign pmax     = (sample   > pair) ? sample   : pair;
   assign vmax     = (lb_rdata > pmax) ? lb_rdata : pmax;

`ifdef MAXPOOL_RELU_EN
   assign result   = vmax[DATA_WIDTH-1] ? '0 : vmax;
`else
   assign result   = vmax;
`endif

   maxpool_line_buf #(
      .DEPTH      (LB_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (LB_AW)
   ) u_line_buf (
      .i_clk   (i_clk),
      .i_we    (lb_we),
      .i_waddr (lb_addr),
      .i_wdata (pmax),
      .i_raddr (lb_addr),
      .o_rdata (lb_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order in this block.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state      <= IDLE;
         cfg_width  <= '0;
         cfg_height <= '0;
         cfg_max_ch <= '0;
         col        <= '0;
         row        <= '0;
         ch         <= '0;
         addr_cnt   <= '0;
         pair       <= '0;
         o_addr     <= '0;
         o_we       <= 1'b0;
         o_data     <= '0;
         o_done     <= 1'b0;
      end else begin
         o_we   <= 1'b0;
         o_done <= 1'b0;

         case (state)
            IDLE: begin
               if (i_start) begin
                  cfg_width  <= i_width;
                  cfg_height <= i_height;
                  cfg_max_ch <= i_max_ch;
                  col        <= '0;
                  row        <= '0;
                  ch         <= '0;
                  addr_cnt   <= '0;
                  pair       <= '0;
                  o_addr     <= '0;
                  // An empty pass has nothing to count; finish straight away.
                  if ((i_width == 8'd0) || (i_height == 8'd0) || (i_max_ch == 10'd0)) begin
                     state <= FLUSH;
                  end else begin
                     state <= RUN;
                  end
               end
            end

            RUN: begin
               if (i_valid) begin
                  if (!col[0]) begin
                     pair <= sample;
                  end else if (row[0]) begin
                     // Bottom-right of a complete 2x2 window.
                     o_we     <= 1'b1;
                     o_data   <= result;
                     o_addr   <= addr_cnt;
                     addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                  end

                  if (col_last) begin
                     col <= '0;
                     if (row_last) begin
                        row <= '0;
                        ch  <= ch + 10'd1;
                        if (ch_last) begin
                           state <= FLUSH;
                        end
                     end else begin
                        row <= row + 8'd1;
                     end
                  end else begin
                     col <= col + 8'd1;
                  end
               end
            end

            FLUSH: begin
               // The final write (if any) is on the outputs this cycle.
               o_done <= 1'b1;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : maxpool2d_stream

// File: tb/tb_maxpool2d_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2d_stream
//
// Self-checking bench for maxpool2d_stream. Each pass builds an input image,
// computes the expected pooled outputs directly from the 2x2 floor-pooling
// definition, drives the stream and compares every BRAM write (address, data,
// cycle) plus o_done timing. Honours MAXPOOL_RELU_EN the same way as the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_maxpool2d_stream;
   import maxpool2d_stream_pkg::*;

   localparam int DW = 16;
   localparam int AW = 18;

   logic          i_clk    = 1'b0;
   logic          i_rst    = 1'b0;
   logic          i_start  = 1'b0;
   logic [7:0]    i_width  = '0;
   logic [7:0]    i_height = '0;
   logic [9:0]    i_max_ch = '0;
   logic [DW-1:0] i_data   = '0;
   logic          i_valid  = 1'b0;
   logic [AW-1:0] o_addr;
   logic          o_we;
   logic [DW-1:0] o_data;
   logic          o_done;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Observed traffic, appended by the monitor.
   logic [AW-1:0]        wr_addr_q [$];
   logic signed [DW-1:0] wr_data_q [$];
   int                   wr_cyc_q  [$];
   int                   done_cyc_q[$];

   // Current pass stimulus and the cycle each sample was presented.
   logic signed [DW-1:0] stim     [$];
   int                   in_cyc_q [$];

   maxpool2d_stream #(
      .DATA_WIDTH (DW),
      .LB_DEPTH   (128),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_width  (i_width),
      .i_height (i_height),
      .i_max_ch (i_max_ch),
      .i_data   (i_data),
      .i_valid  (i_valid),
      .o_addr   (o_addr),
      .o_we     (o_we),
      .o_data   (o_data),
      .o_done   (o_done)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_we) begin
         wr_addr_q.push_back(o_addr);
         wr_data_q.push_back($signed(o_data));
         wr_cyc_q.push_back(cyc);
      end
      if (o_done) begin
         done_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // pattern: 0 = raster index, 1 = random, 2 = all -7, 3 = random with
   // signed extremes planted in the first 5x3 channel.
   task automatic run_pass(input string name, input int w, input int h, input int nch,
                           input int pattern, input bit gaps, output int base);
      logic signed [DW-1:0] exp_data[$];
      int                   exp_src [$];
      logic [31:0]          r;
      logic signed [31:0]   m;
      int                   base_done;
      int                   start_cyc;
      int                   exp_done;
      int                   n;
      int                   k;

      stim.delete();
      in_cyc_q.delete();
      for (int i = 0; i < nch * h * w; i++) begin
         r = $urandom;
         case (pattern)
            0:       stim.push_back(DW'(i));
            2:       stim.push_back(-16'sd7);
            default: stim.push_back(r[DW-1:0]);
         endcase
      end
      if (pattern == 3) begin
         stim[0]  = 16'sh8000;  stim[1]  = 16'sd5;
         stim[5]  = -16'sd3;    stim[6]  = -16'sd100;
         stim[2]  = 16'sh7fff;  stim[3]  = 16'sh8000;
         stim[7]  = 16'sd0;     stim[8]  = -16'sd1;
         stim[4]  = 16'sh7fff;  stim[9]  = 16'sh7fff;
         stim[10] = 16'sh7fff;  stim[11] = 16'sh7fff;
      end

      // Reference: floor 2x2 pooling, channel/row/column order.
      for (int c = 0; c < nch; c++) begin
         for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
               m = stim[(c * h + 2 * pr) * w + 2 * pc];
               for (int dr = 0; dr < 2; dr++) begin
                  for (int dc = 0; dc < 2; dc++) begin
                     k = (c * h + 2 * pr + dr) * w + 2 * pc + dc;
                     if (stim[k] > m) m = stim[k];
                  end
               end
`ifdef MAXPOOL_RELU_EN
               if (m < 0) m = 0;
`endif
               exp_data.push_back(m[DW-1:0]);
               exp_src.push_back((c * h + 2 * pr + 1) * w + 2 * pc + 1);
            end
         end
      end

      base      = wr_data_q.size();
      base_done = done_cyc_q.size();

      i_width   = w[7:0];
      i_height  = h[7:0];
      i_max_ch  = nch[9:0];
      i_start   = 1'b1;
      start_cyc = cyc;
      tick();
      i_start   = 1'b0;
      // Dimensions must be latched; scramble the live inputs.
      r         = $urandom;
      i_width   = r[7:0];
      i_height  = r[15:8];
      i_max_ch  = r[25:16];

      for (int i = 0; i < stim.size(); i++) begin
         if (gaps) begin
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
               i_valid = 1'b0;
               i_data  = DW'($urandom);
               i_start = 1'($urandom_range(0, 1));
               tick();
            end
            i_start = 1'b0;
         end
         i_valid = 1'b1;
         i_data  = stim[i];
         in_cyc_q.push_back(cyc);
         tick();
      end
      i_valid = 1'b0;

      exp_done = (stim.size() == 0) ? start_cyc + 2 : in_cyc_q[$] + 2;

      n = 0;
      while (done_cyc_q.size() == base_done && n < 40) begin
         tick();
         n++;
      end
      repeat (3) tick();

      check($sformatf("%s_done_count", name), done_cyc_q.size() - base_done, 1);
      if (done_cyc_q.size() > base_done) begin
         check($sformatf("%s_done_cycle", name), done_cyc_q[base_done], exp_done);
      end
      check($sformatf("%s_num_writes", name), wr_data_q.size() - base, exp_data.size());
      for (int i = 0; i < exp_data.size() && base + i < wr_data_q.size(); i++) begin
         check($sformatf("%s_addr[%0d]", name, i), wr_addr_q[base + i], i);
         check($sformatf("%s_data[%0d]", name, i), wr_data_q[base + i], exp_data[i]);
         check($sformatf("%s_wcyc[%0d]", name, i), wr_cyc_q[base + i],
               in_cyc_q[exp_src[i]] + 1);
      end
      check($sformatf("%s_final_addr", name), o_addr,
            (exp_data.size() > 0) ? exp_data.size() - 1 : 0);
      check($sformatf("%s_we_idle", name), o_we, 0);
   endtask

   initial begin
      int b;
      int bd;
      int s1_exp[4];
      int w;
      int h;
      int c;

      s1_exp = '{5, 7, 13, 15};

      // Reset values.
      i_rst = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_we",    o_we,      0);
      check("rst_done",  o_done,    0);
      check("rst_addr",  o_addr,    0);
      check("rst_data",  o_data,    0);
      check("rst_state", dut.state, IDLE);
      i_rst = 1'b1;
      tick();

      // i_valid in IDLE must not produce writes or done.
      for (int i = 0; i < 4; i++) begin
         i_valid = 1'b1;
         i_data  = DW'($urandom);
         tick();
      end
      i_valid = 1'b0;
      repeat (3) tick();
      check("idle_no_writes", wr_data_q.size(),  0);
      check("idle_no_done",   done_cyc_q.size(), 0);

      // 4x4, 1 channel, raster 0..15.
      run_pass("s1", 4, 4, 1, 0, 1'b0, b);
`ifndef MAXPOOL_RELU_EN
      for (int i = 0; i < 4 && b + i < wr_data_q.size(); i++) begin
         check($sformatf("s1_literal[%0d]", i), wr_data_q[b + i], s1_exp[i]);
      end
`endif

      // 5x3, 2 channels, signed extremes, odd column/row dropped.
      run_pass("s2", 5, 3, 2, 3, 1'b1, b);

      // 2x2, 3 channels, all -7 (written as 0 when ReLU is fused).
      run_pass("s3", 2, 2, 3, 2, 1'b0, b);

      // Random shapes, random data, random gaps and ignored start pulses.
      for (int t = 0; t < 4; t++) begin
         w = $urandom_range(1, 12);
         h = $urandom_range(1, 9);
         c = $urandom_range(1, 3);
         run_pass($sformatf("rnd%0d", t), w, h, c, 1, 1'b1, b);
      end

      // Width 1: no writes, done after the 8th input.
      run_pass("w1", 1, 8, 1, 1, 1'b0, b);

      // Zero channels: done two cycles after start.
      run_pass("ch0", 4, 4, 0, 1, 1'b0, b);

      // Abort mid-pass with reset after 10 inputs.
      i_width  = 8'd4;
      i_height = 8'd4;
      i_max_ch = 10'd1;
      i_start  = 1'b1;
      tick();
      i_start  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         i_valid = 1'b1;
         i_data  = DW'(i);
         tick();
      end
      i_valid = 1'b0;
      bd      = done_cyc_q.size();
      i_rst   = 1'b0;
      #2;
      check("abort_we",    o_we,      0);
      check("abort_done",  o_done,    0);
      check("abort_data",  o_data,    0);
      check("abort_state", dut.state, IDLE);
      repeat (3) tick();
      i_rst = 1'b1;
      repeat (3) tick();
      check("abort_no_done", done_cyc_q.size() - bd, 0);

      run_pass("s1b", 4, 4, 1, 0, 1'b0, b);
`ifndef MAXPOOL_RELU_EN
      for (int i = 0; i < 4 && b + i < wr_data_q.size(); i++) begin
         check($sformatf("s1b_literal[%0d]", i), wr_data_q[b + i], s1_exp[i]);
      end
`endif

      // 254x254 at full rate.
      run_pass("big", 254, 254, 1, 1, 1'b0, b);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_maxpool2d_stream
